sub_a: RTL and testbench
========================

// Module: sub_a
// PURPOSE
// - Single-bit input conditioner: synchronises asynchronous in_bit1 into the clk domain.
// - Glitch-filters the synchronised bit and drives a clean, registered out_bit1.
// - Emits one-cycle rise/fall pulses on every filtered transition.
// - Sits between a raw external/status bit and downstream control logic.
// PARAMETERS
// - SYNC_STAGES    2   synchroniser flop count (legal: >=2)
// - STABLE_CYCLES  3   consecutive differing samples required to accept a new level (legal: >=1)
// - RST_VAL        1'b0 reset level of synchroniser flops and out_bit1
// - CNT_W          8   toggle counter width (used only with SUB_A_TOGGLE_CNT_EN)
// PORTS
// - clk         in   1      sole clock, rising edge
// - rst         in   1      synchronous, active-high reset
// - in_bit1     in   1      raw input, asynchronous to clk
// - out_bit1    out  1      filtered, registered level
// - rise_pulse  out  1      1-cycle pulse, out_bit1 went 0->1
// - fall_pulse  out  1      1-cycle pulse, out_bit1 went 1->0
// - toggle_cnt  out  CNT_W  filtered transition count (zero without macro)
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is synchronous and active-high.
// - All state updates on posedge clk only.
// - Reset (rst=1 at a posedge), also valid mid-operation:
//   - sync chain = RST_VAL; out_bit1 = RST_VAL
//   - filter count = 0; rise_pulse = fall_pulse = 0; toggle_cnt = 0
//   - rst has priority over all other updates.
// - Synchroniser: SYNC_STAGES-deep shift chain; sync_q = last stage.
// - Filter (count width $clog2(STABLE_CYCLES+1)):
//   - sync_q == out_bit1: count <= 0.
//   - sync_q != out_bit1 and count < STABLE_CYCLES-1: count <= count+1.
//   - sync_q != out_bit1 and count == STABLE_CYCLES-1: out_bit1 <= sync_q; count <= 0.
// - Latency: clean step sampled at edge 1 appears on out_bit1 at edge SYNC_STAGES+STABLE_CYCLES.
//   - Defaults: 5 edges.
// - Glitches: any sync_q pulse shorter than STABLE_CYCLES cycles never reaches out_bit1; count restarts.
// - Pulses: rise_pulse/fall_pulse registered, high exactly in the cycle out_bit1 holds its new value.
//   - Both low otherwise; never both high.
// - No pulse is generated by reset itself, even if out_bit1 changes level due to reset.
// CONFIGURATION
// - Macro SUB_A_TOGGLE_CNT_EN:
//   - Defined: toggle_cnt increments by 1 on each cycle where rise_pulse or fall_pulse is high.
//     It saturates at 2**CNT_W-1 (no wrap).
//   - Not defined: counter logic omitted; toggle_cnt tied to 0; port still present.
// TESTING (clk period 20ns, posedges at 10,30,..; defaults)
// - rst high 2 cycles -> out_bit1=0, pulses=0, toggle_cnt=0.
// - in_bit1 0->1 at 100ns -> out_bit1=1 at 190ns edge; rise_pulse high 190-210ns.
// - in_bit1 1->0 at 200ns, 0->1 at 300ns -> fall at 290ns edge, rise at 390ns edge.
//   - With macro: toggle_cnt=3 after 390ns.
// - 1-cycle and 2-cycle high glitches on in_bit1 -> out_bit1 stays 0, no pulses.
// - rst asserted while count=2 and sync_q=1 -> next edge: out_bit1=0, count=0.
//   - After rst release: new full 5-edge latency.
// - With macro and CNT_W=2, drive 5 clean toggles -> toggle_cnt saturates at 3.

Source files
------------

// File: rtl/sub_a.sv
// sub_a: single-bit input conditioner -- synchroniser, glitch filter and edge pulses.
// Defining SUB_A_TOGGLE_CNT_EN adds a saturating filtered-transition counter on toggle_cnt.
module sub_a #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 3,
  parameter logic RST_VAL       = 1'b0,
  parameter int   CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit1,
  output logic             out_bit1,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int FCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [FCW-1:0] FCNT_ZERO = {FCW{1'b0}};
  localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_bit;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit1};
  end

  // A new level is accepted only after STABLE_CYCLES consecutive differing samples.
  always_comb begin
    fcnt_d = fcnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_bit == out_q) begin
      fcnt_d = FCNT_ZERO;
    end else if (fcnt_q == FCNT_LAST) begin
      fcnt_d = FCNT_ZERO;
      out_d  = sync_bit;
      rise_d = sync_bit;
      fall_d = ~sync_bit;
    end else begin
      fcnt_d = fcnt_q + FCNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      fcnt_q <= FCNT_ZERO;
      out_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_bit1   = out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef SUB_A_TOGGLE_CNT_EN
  localparam logic [CNT_W-1:0] TCNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TCNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TCNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  // Counts alongside the pulse it accompanies and holds at all-ones instead of wrapping.
  always_comb begin
    tcnt_d = tcnt_q;
    if ((rise_d || fall_d) && (tcnt_q != TCNT_MAX)) begin
      tcnt_d = tcnt_q + TCNT_ONE;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= TCNT_ZERO;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign toggle_cnt = tcnt_q;
`else
  assign toggle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sub_a.sv
// tb_sub_a: directed + randomized stimulus for sub_a, checked every cycle against a
// sliding-window reference model of the input history.
module tb_sub_a;

  localparam int   SS       = 2;
  localparam int   SC       = 3;
  localparam logic RV       = 1'b0;
  localparam int   TB_CNT_W = 4;
  localparam int   TMAX     = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic                in_bit1;
  logic                out_bit1;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [TB_CNT_W-1:0] toggle_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference state: samples of in_bit1 taken at each edge since the last reset.
  bit hist[$];
  bit m_out  = RV;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;
  int m_tog  = 0;

  sub_a #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .RST_VAL      (RV),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit1   (in_bit1),
    .out_bit1  (out_bit1),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_cnt(toggle_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // The filter acting at an edge sees the input sampled SS edges earlier; the level
  // flips when the last SC such samples all differ from the current output.
  task automatic model_edge(input logic r, input logic b);
    int  n;
    bit  all_diff;
    if (r) begin
      hist = {};
      repeat (SS + SC) hist.push_back(RV);
      m_out  = RV;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_tog  = 0;
    end else begin
      hist.push_back(b);
      n = hist.size() - 1;
      all_diff = 1'b1;
      for (int k = 0; k < SC; k++) begin
        if (hist[n - SS - k] == m_out) all_diff = 1'b0;
      end
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (all_diff) begin
        m_out  = ~m_out;
        m_rise = m_out;
        m_fall = ~m_out;
        if (m_tog < TMAX) m_tog++;
      end
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  task automatic step(input logic r, input logic b);
    int exp_tog;
    rst     = r;
    in_bit1 = b;
    @(posedge clk);
    model_edge(r, b);
    @(negedge clk);
`ifdef SUB_A_TOGGLE_CNT_EN
    exp_tog = m_tog;
`else
    exp_tog = 0;
`endif
    check("out_bit1",   32'(out_bit1),   32'(m_out));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("both_pulse", 32'(rise_pulse & fall_pulse), 32'(0));
    check("toggle_cnt", 32'(toggle_cnt), 32'(exp_tog));
  endtask

  initial begin
    int  hold;
    bit  val;
    rst     = 1'b1;
    in_bit1 = 1'b0;
    repeat (SS + SC) hist.push_back(RV);

    // Reset for two cycles, then clean steps with full settling time.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (3)  step(1'b0, 1'b0);
    repeat (5)  step(1'b0, 1'b1);
    repeat (5)  step(1'b0, 1'b0);
    repeat (6)  step(1'b0, 1'b1);
    repeat (6)  step(1'b0, 1'b0);

    // One- and two-cycle glitches must be swallowed.
    step(1'b0, 1'b1);
    repeat (6)  step(1'b0, 1'b0);
    repeat (2)  step(1'b0, 1'b1);
    repeat (6)  step(1'b0, 1'b0);

    // Reset while the filter is part-way to accepting a high level.
    repeat (4)  step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (8)  step(1'b0, 1'b1);
    repeat (6)  step(1'b0, 1'b0);

    // Clean toggles to push the counter to saturation.
    for (int t = 0; t < 20; t++) begin
      repeat (4) step(1'b0, ((t % 2) == 0) ? 1'b1 : 1'b0);
    end

    // Random hold lengths straddling the acceptance threshold, with occasional resets.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        hold = $urandom_range(1, 7);
        val  = 1'($urandom_range(0, 1));
        repeat (hold) step(1'b0, val);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
